// File: rtl/reg_write_arbiter_pkg.sv
// Shared types, default parameters and width helper for the register write arbiter.
package reg_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_NREG  = 4;
   localparam int DEF_WIDTH = 4;

   // Index width that never collapses to zero bits for tiny counts.
   function automatic int clog2_safe(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or after ptr, wrapping; one-hot gnt plus index.
module rr_picker
   import reg_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int PW   = clog2_safe(DEF_NREQ)
)
(
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   idx
);

   int best_s;

   // rotated-order distance from ptr acts as the priority; smallest distance wins
   always_comb begin
      best_s = NREQ;
      idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i] && (((i + NREQ - int'(ptr)) % NREQ) < best_s)) begin
            best_s = (i + NREQ - int'(ptr)) % NREQ;
            idx    = PW'(i);
         end else begin
            best_s = best_s;
         end
      end
   end

   // un-rotate the winner back into a one-hot grant
   always_comb begin
      gnt = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt[i] = req[i] && (idx == PW'(i));
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of a bank of load-enabled registers.
// Optional saturating conflict counter enabled by REGARB_CONFLICT_CNT_EN.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int NREG  = DEF_NREG,
   parameter int WIDTH = DEF_WIDTH,
   localparam int AW   = clog2_safe(NREG),
   localparam int PW   = clog2_safe(NREQ)
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*AW-1:0]    req_addr,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       ack,
   output logic [NREG-1:0]       reg_load,
   output logic [WIDTH-1:0]      reg_d,
   output logic                  busy
`ifdef REGARB_CONFLICT_CNT_EN
   ,output logic [7:0]           conflict_cnt
`endif
);

   state_t            state_r, state_s;
   logic [NREQ-1:0]   gnt_s;
   logic [PW-1:0]     idx_s;
   logic [PW-1:0]     rr_ptr_r;
   logic [PW-1:0]     k_r;
   logic [AW-1:0]     addr_r, sel_addr_s;
   logic [WIDTH-1:0]  data_r, sel_data_s;

   rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
      .req (req),
      .ptr (rr_ptr_r),
      .gnt (gnt_s),
      .idx (idx_s)
   );

   // select the winner's address and data slices
   always_comb begin
      sel_addr_s = '0;
      sel_data_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (idx_s == PW'(i)) begin
            sel_addr_s = req_addr[i*AW +: AW];
            sel_data_s = req_data[i*WIDTH +: WIDTH];
         end else begin
            sel_addr_s = sel_addr_s;
         end
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // next state: a grant always commits to exactly one LOAD cycle
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = (|gnt_s) ? LOAD : IDLE;
         LOAD:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // grant latches and round-robin pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         k_r      <= '0;
         addr_r   <= '0;
         data_r   <= '0;
         rr_ptr_r <= '0;
      end else if ((state_r == IDLE) && (|gnt_s)) begin
         k_r    <= idx_s;
         addr_r <= sel_addr_s;
         data_r <= sel_data_s;
      end else if (state_r == LOAD) begin
         rr_ptr_r <= (k_r == PW'(NREQ - 1)) ? '0 : k_r + PW'(1);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // output decode from registered state only
   always_comb begin
      ack      = '0;
      reg_load = '0;
      busy     = 1'b0;
      case (state_r)
         LOAD: begin
            busy = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
               ack[i] = (k_r == PW'(i));
            end
            for (int j = 0; j < NREG; j++) begin
               reg_load[j] = (addr_r == AW'(j));
            end
         end
         IDLE:    busy = 1'b0;
         default: busy = 1'b0;
      endcase
   end

   // reg_d keeps the last latched data; reg_load alone qualifies it
   assign reg_d = data_r;

`ifdef REGARB_CONFLICT_CNT_EN
   logic [7:0] conflict_cnt_r;

   // saturating count of grants made while two or more requesters competed
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_cnt_r <= 8'd0;
      end else if ((state_r == IDLE) && ($countones(req) >= 2) && (conflict_cnt_r != 8'd255)) begin
         conflict_cnt_r <= conflict_cnt_r + 8'd1;
      end else begin
         conflict_cnt_r <= conflict_cnt_r;
      end
   end

   assign conflict_cnt = conflict_cnt_r;
`endif

endmodule
